// File: rtl/descrambler_pkg.sv
// Shared packet types, the link scrambling pair and the CRC-8 used on the receive path.
package definitions;

   localparam logic [7:0] CRC8_POLY = 8'h07;

   typedef struct packed {
      logic [7:0] head;
      logic [7:0] dst;
      logic [7:0] pay;
      logic [7:0] crc;
   } packet_in_t;

   typedef struct packed {
      logic [7:0] w0;
      logic [7:0] w1;
      logic [7:0] w2;
      logic [7:0] w3;
   } packet_out_t;

   typedef enum logic {OUT_IDLE, OUT_WAIT} out_state_t;

   function automatic packet_out_t scrambling_packet(input packet_in_t p);
      packet_out_t s;
      s.w0 = {p.head[6:0], p.head[7]} ^ 8'h5A;
      s.w1 = p.dst ^ p.head;
      s.w2 = p.pay ^ p.dst ^ 8'h3C;
      s.w3 = p.crc ^ 8'hC3;
      return s;
   endfunction

   // Undo the fields in dependency order: head first, since dst and pay are chained on it.
   function automatic packet_in_t descrambling_packet(input packet_out_t s);
      packet_in_t p;
      logic [7:0] h;
      h      = s.w0 ^ 8'h5A;
      p.head = {h[0], h[7:1]};
      p.dst  = s.w1 ^ p.head;
      p.pay  = s.w2 ^ p.dst ^ 8'h3C;
      p.crc  = s.w3 ^ 8'hC3;
      return p;
   endfunction

   function automatic logic [7:0] crc8(input logic [7:0] head, input logic [7:0] dst,
                                       input logic [7:0] pay);
      logic [7:0]  c;
      logic [23:0] msg;
      c   = 8'h00;
      msg = {head, dst, pay};
      for (int i = 23; i >= 0; i--) begin
         c = (c[7] ^ msg[i]) ? ((c << 1) ^ CRC8_POLY) : (c << 1);
      end
      return c;
   endfunction

endpackage

// File: rtl/descrambler_if.sv
// Two-phase toggle handshake link: a transfer is pending while req != ack.
interface bus import definitions::*; #(
   parameter type T = packet_in_t
);
   logic req;
   logic ack;
   T     data;

   modport master (output req, output data, input ack);
   modport slave  (input req, input data, output ack);
endinterface

// File: rtl/descrambler_pkt_fifo.sv
// Synchronous FIFO; storage is not reset, only pointers and occupancy.
module pkt_fifo import definitions::*; #(
   parameter int  DEPTH = 4,
   parameter type T     = packet_in_t
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   push,
   input  T                       din,
   input  logic                   pop,
   output T                       dout,
   output logic                   full,
   output logic                   empty,
   output logic [$clog2(DEPTH):0] level
);
   localparam int AW = $clog2(DEPTH);

   T              mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [AW:0]   cnt;

   always_ff @(posedge clk) begin
      if (!rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   cnt <= cnt + 1'b1;
            2'b01:   cnt <= cnt - 1'b1;
            default: cnt <= cnt;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= din;
   end

   // Upstream gating must make these unreachable.
   always_ff @(posedge clk) begin
      if (rst) begin
         assert (!(push && full));
         assert (!(pop && empty));
      end
   end

   assign dout  = mem[rd_ptr];
   assign full  = (cnt == (AW + 1)'(DEPTH));
   assign empty = (cnt == '0);
   assign level = cnt;
endmodule

// File: rtl/descrambler.sv
// Receive path: descramble, CRC-8 check, buffer and forward packets over toggle links.
module descrambler import definitions::*; #(
   parameter int DEPTH    = 4,
   parameter int DROP_BAD = 1,
   parameter int CNT_W    = 16
) (
   input  logic                   clk,
   input  logic                   rst,
   bus.slave                      ser2dsc,
   bus.master                     dsc2des,
   output logic                   crc_err,
   output logic [CNT_W-1:0]       pkt_cnt,
   output logic [CNT_W-1:0]       err_cnt,
   output logic [$clog2(DEPTH):0] fifo_lvl
);
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction

   logic       ack_lvl;
   logic       take;
   logic       vld_p1;
   logic       crc_ok_p1;
   logic       push;
   logic       pop;
   logic       load;
   logic       fifo_empty;
   logic       fifo_full;
   logic       req_lvl;
   packet_in_t pkt_p1;
   packet_in_t fifo_head;
   packet_in_t out_data;
   out_state_t state;
   out_state_t state_nx;

   // Room counts the packet already in flight so a capture can never overflow the FIFO.
   assign take = (ser2dsc.req != ack_lvl) && !fifo_full
                 && ((int'(fifo_lvl) + int'(vld_p1)) < DEPTH);

   // capture -> p1
   always_ff @(posedge clk) begin
      if (!rst) begin
         ack_lvl <= 1'b0;
         vld_p1  <= 1'b0;
      end else begin
         ack_lvl <= ack_lvl ^ take;
         vld_p1  <= take;
      end
   end

   always_ff @(posedge clk) begin
      if (take) pkt_p1 <= descrambling_packet(ser2dsc.data);
   end

   assign crc_ok_p1 = (crc8(pkt_p1.head, pkt_p1.dst, pkt_p1.pay) == pkt_p1.crc);
   assign push      = vld_p1 && (crc_ok_p1 || (DROP_BAD == 0));

   // p1 -> FIFO and statistics
   always_ff @(posedge clk) begin
      if (!rst) begin
         crc_err <= 1'b0;
         pkt_cnt <= '0;
         err_cnt <= '0;
      end else begin
         crc_err <= vld_p1 && !crc_ok_p1;
         if (vld_p1)               pkt_cnt <= sat_inc(pkt_cnt);
         if (vld_p1 && !crc_ok_p1) err_cnt <= sat_inc(err_cnt);
      end
   end

   pkt_fifo #(.DEPTH(DEPTH), .T(packet_in_t)) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .din   (pkt_p1),
      .pop   (pop),
      .dout  (fifo_head),
      .full  (fifo_full),
      .empty (fifo_empty),
      .level (fifo_lvl)
   );

   // FIFO head -> output link; the entry stays queued until the consumer acknowledges.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state    <= OUT_IDLE;
         req_lvl  <= 1'b0;
         out_data <= '0;
      end else begin
         state <= state_nx;
         if (load) begin
            req_lvl  <= ~req_lvl;
            out_data <= fifo_head;
         end
      end
   end

   always_comb begin
      state_nx = state;
      load     = 1'b0;
      pop      = 1'b0;
      case (state)
         OUT_IDLE: begin
            if (!fifo_empty) begin
               load     = 1'b1;
               state_nx = OUT_WAIT;
            end
         end
         OUT_WAIT: begin
            if (dsc2des.ack == req_lvl) begin
               pop      = 1'b1;
               state_nx = OUT_IDLE;
            end
         end
         default: state_nx = OUT_IDLE;
      endcase
   end

   assign ser2dsc.ack  = ack_lvl;
   assign dsc2des.req  = req_lvl;
   assign dsc2des.data = out_data;
endmodule

// File: tb/tb_descrambler.sv
// Bench for descrambler: scoreboard of plaintext packets versus what each DUT delivers.
module tb_descrambler;
   import definitions::*;

   logic clk;
   logic rst;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   bus #(.T(packet_out_t)) sa ();
   bus #(.T(packet_in_t))  da ();
   bus #(.T(packet_out_t)) sb ();
   bus #(.T(packet_in_t))  db ();

   logic        crc_err_a, crc_err_b;
   logic [15:0] pkt_cnt_a, err_cnt_a;
   logic [3:0]  pkt_cnt_b, err_cnt_b;
   logic [2:0]  lvl_a, lvl_b;

   descrambler #(.DEPTH(4), .DROP_BAD(1), .CNT_W(16)) dut_a (
      .clk(clk), .rst(rst), .ser2dsc(sa), .dsc2des(da), .crc_err(crc_err_a),
      .pkt_cnt(pkt_cnt_a), .err_cnt(err_cnt_a), .fifo_lvl(lvl_a)
   );

   descrambler #(.DEPTH(4), .DROP_BAD(0), .CNT_W(4)) dut_b (
      .clk(clk), .rst(rst), .ser2dsc(sb), .dsc2des(db), .crc_err(crc_err_b),
      .pkt_cnt(pkt_cnt_b), .err_cnt(err_cnt_b), .fifo_lvl(lvl_b)
   );

   int n_cmp = 0;
   int n_fail = 0;
   int cyc = 0;
   packet_in_t qa[$];
   packet_in_t qb[$];
   int tog_a = 0, tog_b = 0, exp_tog_a = 0, exp_tog_b = 0;
   int pulse_a = 0, pulse_b = 0;
   int pkt_a = 0, err_a = 0, pkt_b = 0, err_b = 0;
   int in_cyc_a = 0, out_cyc_a = 0;
   bit hold_a = 0, hold_b = 0, stream_chk = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // CRC as the remainder of msg * x^8 divided by x^8+x^2+x+1.
   function automatic logic [7:0] ref_crc(input logic [7:0] h, input logic [7:0] d,
                                          input logic [7:0] p);
      logic [31:0] r;
      r = {h, d, p, 8'h00};
      for (int i = 31; i >= 8; i--)
         if (r[i]) r[i -: 9] = r[i -: 9] ^ 9'h107;
      return r[7:0];
   endfunction

   function automatic packet_in_t mk(input logic [7:0] h, input logic [7:0] d,
                                     input logic [7:0] p, input bit bad);
      packet_in_t x;
      x.head = h;
      x.dst  = d;
      x.pay  = p;
      x.crc  = ref_crc(h, d, p) ^ (bad ? 8'h01 : 8'h00);
      return x;
   endfunction

   function automatic int sat(input int n, input int w);
      return (n > (1 << w) - 1) ? (1 << w) - 1 : n;
   endfunction

   task automatic start(input int which, input packet_in_t p);
      bit good;
      good = (ref_crc(p.head, p.dst, p.pay) == p.crc);
      @(posedge clk); #1;
      if (which == 0) begin
         pkt_a++;
         if (!good) err_a++;
         if (good) begin
            qa.push_back(p);
            exp_tog_a++;
         end
         sa.data  = scrambling_packet(p);
         sa.req   = ~sa.req;
         in_cyc_a = cyc;
      end else begin
         pkt_b++;
         if (!good) err_b++;
         qb.push_back(p);
         exp_tog_b++;
         sb.data = scrambling_packet(p);
         sb.req  = ~sb.req;
      end
   endtask

   task automatic wait_ack(input int which, input int limit, output bit got);
      got = 0;
      for (int i = 0; i < limit && !got; i++) begin
         @(posedge clk); #1;
         got = (which == 0) ? (sa.ack == sa.req) : (sb.ack == sb.req);
      end
   endtask

   task automatic send(input int which, input packet_in_t p, input string name);
      bit got;
      start(which, p);
      wait_ack(which, 40, got);
      check(name, got, 1);
   endtask

   task automatic drain(input int limit, input string name);
      for (int i = 0; i < limit && (qa.size() != 0 || qb.size() != 0); i++) @(posedge clk);
      repeat (4) @(posedge clk);
      #1;
      check(name, qa.size() + qb.size(), 0);
   endtask

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   // Downstream consumer: acknowledges immediately unless held.
   initial begin
      da.ack = 1'b0;
      db.ack = 1'b0;
      forever begin
         @(posedge clk); #1;
         if (!rst) begin
            da.ack = 1'b0;
            db.ack = 1'b0;
         end else begin
            if (!hold_a) da.ack = da.req;
            if (!hold_b) db.ack = db.req;
         end
      end
   end

   // Compare process: every new output transfer must match the scoreboard head.
   initial begin
      logic last_a, last_b;
      last_a = 1'b0;
      last_b = 1'b0;
      forever begin
         @(negedge clk);
         if (!rst) begin
            last_a = 1'b0;
            last_b = 1'b0;
         end else begin
            if (crc_err_a) pulse_a++;
            if (crc_err_b) pulse_b++;
            if (stream_chk) check("stream_lvl_a_gt2", lvl_a > 3'd2, 0);
            if (da.req !== last_a) begin
               last_a    = da.req;
               tog_a++;
               out_cyc_a = cyc;
               if (qa.size() == 0) check("unexpected_out_a", qa.size(), 1);
               else                check("data_a", da.data, qa.pop_front());
            end
            if (db.req !== last_b) begin
               last_b = db.req;
               tog_b++;
               if (qb.size() == 0) check("unexpected_out_b", qb.size(), 1);
               else                check("data_b", db.data, qb.pop_front());
            end
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      bit         got;
      packet_in_t p;
      rst     = 1'b0;
      sa.req  = 1'b0;
      sa.data = '0;
      sb.req  = 1'b0;
      sb.data = '0;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b1;

      check("rst_lvl_a", lvl_a, 0);
      check("rst_pkt_cnt_a", pkt_cnt_a, 0);
      check("rst_err_cnt_a", err_cnt_a, 0);
      check("rst_crc_err_a", crc_err_a, 0);
      check("rst_out_req_a", da.req, 0);
      check("rst_in_ack_a", sa.ack, 0);
      check("rst_out_data_a", da.data, 0);
      check("pin_crc_010000", ref_crc(8'h01, 8'h00, 8'h00), 8'h6B);
      check("pin_crc_020000", ref_crc(8'h02, 8'h00, 8'h00), 8'hD6);

      // round trip
      send(0, '{head: 8'h01, dst: 8'h00, pay: 8'h00, crc: 8'h6B}, "rt_ack");
      drain(40, "rt_drain");
      check("rt_latency", out_cyc_a - in_cyc_a, 3);
      check("rt_data_lit", da.data, 32'h0100006B);
      check("rt_pkt_cnt", pkt_cnt_a, 1);
      check("rt_err_cnt", err_cnt_a, 0);
      check("rt_crc_pulses", pulse_a, 0);

      // bad CRC, dropped
      send(0, '{head: 8'h01, dst: 8'h00, pay: 8'h00, crc: 8'h6A}, "bad_a_ack");
      repeat (10) @(posedge clk);
      #1;
      check("bad_a_err_cnt", err_cnt_a, 1);
      check("bad_a_pulses", pulse_a, 1);
      check("bad_a_no_out", tog_a, exp_tog_a);
      check("bad_a_data_held", da.data, 32'h0100006B);

      // bad CRC, forwarded
      send(1, '{head: 8'h01, dst: 8'h00, pay: 8'h00, crc: 8'h6A}, "bad_b_ack");
      drain(40, "bad_b_drain");
      check("bad_b_pulses", pulse_b, 1);
      check("bad_b_err_cnt", err_cnt_b, 1);
      check("bad_b_data_lit", db.data, 32'h0100006A);
      check("bad_b_out", tog_b, exp_tog_b);

      // backpressure
      hold_a = 1;
      for (int i = 0; i < 6; i++) begin
         start(0, mk(8'(8'h10 + i), 8'(8'h20 + i), 8'(8'h30 + i), 0));
         wait_ack(0, 20, got);
         if (i < 4) check("bp_ack", got, 1);
         else if (i == 4) begin
            check("bp_stall", got, 0);
            check("bp_lvl_full", lvl_a, 4);
            hold_a = 0;
            wait_ack(0, 40, got);
            check("bp_resume", got, 1);
         end else check("bp_ack6", got, 1);
      end
      drain(200, "bp_drain");
      check("bp_count", tog_a, exp_tog_a);

      // streaming with immediate downstream ack
      stream_chk = 1;
      for (int i = 0; i < 100; i++) begin
         p = mk(8'($urandom), 8'($urandom), 8'($urandom), (i % 9) == 4);
         send(0, p, "st_ack");
      end
      drain(100, "st_drain");
      stream_chk = 0;
      check("st_count", tog_a, exp_tog_a);
      check("st_pkt_cnt", pkt_cnt_a, sat(pkt_a, 16));
      check("st_err_cnt", err_cnt_a, sat(err_a, 16));
      check("st_pulses", pulse_a, err_a);

      // reset while the output waits with three packets queued
      hold_a = 1;
      for (int i = 0; i < 3; i++) send(0, mk(8'(8'hA0 + i), 8'h5C, 8'(i), 0), "rs_ack");
      repeat (4) @(posedge clk);
      #1;
      check("rs_pre_lvl", lvl_a, 3);
      rst    = 1'b0;
      sa.req = 1'b0;
      sb.req = 1'b0;
      @(posedge clk); #1;
      rst    = 1'b1;
      hold_a = 0;
      qa.delete();
      qb.delete();
      pkt_a = 0; err_a = 0; pkt_b = 0; err_b = 0;
      tog_a = 0; tog_b = 0; exp_tog_a = 0; exp_tog_b = 0;
      pulse_a = 0; pulse_b = 0;
      check("rs_lvl", lvl_a, 0);
      check("rs_out_req", da.req, 0);
      check("rs_in_ack", sa.ack, 0);
      check("rs_pkt_cnt", pkt_cnt_a, 0);
      check("rs_err_cnt", err_cnt_a, 0);
      check("rs_pkt_cnt_b", pkt_cnt_b, 0);
      send(0, mk(8'h7E, 8'h81, 8'h42, 0), "rs_after_ack");
      drain(40, "rs_after_drain");
      check("rs_after_pkt_cnt", pkt_cnt_a, 1);
      check("rs_after_out", tog_a, 1);

      // counter saturation on the narrow-counter instance
      for (int i = 0; i < 20; i++) send(1, mk(8'(i), 8'(~i), 8'h55, 1), "sat_ack");
      drain(200, "sat_drain");
      check("sat_err_cnt", err_cnt_b, sat(err_b, 4));
      check("sat_pkt_cnt", pkt_cnt_b, sat(pkt_b, 4));
      check("sat_err_lit", err_cnt_b, 15);
      check("sat_pulses", pulse_b, 20);
      check("sat_out", tog_b, exp_tog_b);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule

// File: doc/descrambler.md
Name: descrambler

Overview:
- Receive-side counterpart of the scrambler: takes scrambled packets from the serializer-side link and applies the package function `descrambling_packet()`, which is the exact inverse of `scrambling_packet()`.
- Checks the CRC-8 of each recovered packet, buffers good packets in a small FIFO and forwards them to the deserializer-side consumer.
- Both link sides use the 2-phase (toggle req/ack) `bus` interface.
- Single clock domain.

Parameters:
- DEPTH, 4, FIFO entries; power of 2, at least 2.
- DROP_BAD, 1, 1 = discard packets with a CRC mismatch; 0 = forward them and only flag.
- CNT_W, 16, width of the statistics counters.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-low reset (0 = reset).
- ser2dsc  bus.slave  packet_out_t  scrambled packets in.
- dsc2des  bus.master  packet_in_t  descrambled packets out.
- crc_err  out  1  one-cycle pulse per CRC-mismatched packet.
- pkt_cnt  out  CNT_W  packets accepted on ser2dsc, saturating.
- err_cnt  out  CNT_W  CRC-mismatched packets, saturating.
- fifo_lvl  out  $clog2(DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset (rst==0, sampled on clk):
  - FIFO empty, fifo_lvl=0.
  - Counters = 0, crc_err=0.
  - Both bus FSMs idle; ack and req levels = 0; output data = all-zero packet.
  - Reset mid-transfer abandons the transfer; nothing is replayed.
- 2-phase rule: a transfer is pending while req != ack. The slave completes it by toggling ack; the master starts one by toggling req with data held stable until ack matches.
- Input stage:
  - When ser2dsc has a pending req and the FIFO has room for the packet, capture the data in the same cycle and toggle ack on the next edge.
  - Room is computed as fifo_lvl + (stage S1 valid) < DEPTH, so the pipeline can never overflow.
  - If there is no room, ack is held and the upstream side stalls.
- S1 (1 cycle after capture):
  - Register `descrambling_packet(data)`.
  - Compute `crc8(head,dst,pay)`: poly 0x07, init 0x00, MSB-first, bytes in order head, dst, pay.
  - Compare with the `crc` field.
- S2 (end of S1):
  - Match: push to FIFO.
  - Mismatch: pulse crc_err and increment err_cnt; push only if DROP_BAD==0.
  - pkt_cnt increments on every captured packet.
  - Both counters saturate at 2^CNT_W - 1; no wrap.
- Latency: ack toggles 1 cycle after req is seen; the packet reaches the FIFO 2 cycles after capture. The output req toggles at the earliest 1 cycle after the push, i.e. 3 cycles minimum end-to-end.
- Output master FSM:
  - IDLE: if FIFO non-empty, load the head entry into the output register, toggle req, go to WAIT.
  - WAIT: when ack == req, pop the FIFO and go to IDLE. A new transfer may start in the following cycle (one bubble).
- FIFO boundaries:
  - Simultaneous push and pop keeps fifo_lvl unchanged.
  - Push when full cannot occur (guaranteed by the input gating); an assertion checks this.
  - Pop when empty is not possible.
  - Pointers wrap modulo DEPTH.
- Output data holds its value while in WAIT, and after completion until the next load.

Decomposition:
- Add to package `definitions`:
  - `descrambling_packet()` function.
  - `crc8()` function and `CRC8_POLY = 8'h07`.
  - `packet_in_t` / `packet_out_t` are already there.
- One sub-module: `pkt_fifo`, a synchronous FIFO parameterised by DEPTH and element type `packet_in_t`. It provides push, pop, full, empty and level.
- FSMs and the CRC stage stay in the top module.

Test Plan:
- Round trip: drive `scrambling_packet('{head:8'h01,dst:8'h00,pay:8'h00,crc:8'h6B})` → dsc2des delivers `{01,00,00,6B}`; crc_err stays 0; pkt_cnt=1; output req toggles 3 cycles after the input req.
- Bad CRC with DROP_BAD=1: send scrambled `{01,00,00,6A}` → one crc_err pulse, err_cnt=1, no output req toggle. With DROP_BAD=0 → the packet is forwarded unchanged and crc_err still pulses.
- Backpressure: hold dsc2des ack and send 6 valid packets → 4 delivered into the FIFO, fifo_lvl=4, input ack stalls on packet 5. Release ack → all 6 emerge in order with correct data.
- Concurrent push/pop: continuous streaming with immediate downstream ack → fifo_lvl never exceeds 2, no loss or reorder over 100 random packets (scoreboard).
- Reset mid-transfer: assert rst=0 for 1 cycle while the output is in WAIT with 3 packets queued → fifo_lvl=0, req=ack=0, counters=0. The next packet sent after reset is delivered normally.
- Saturation with CNT_W=4: send 20 bad packets → err_cnt holds at 15 and pkt_cnt holds at 15.
